// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode constants, register index width and the
// shadow-entry layout used to track in-flight destination registers.
package pipe_pkg;

  localparam int REG_NUM_BITWIDTH = 5;

  localparam logic [6:0] INST_R     = 7'b0110011;
  localparam logic [6:0] INST_I_LD  = 7'b0000011;
  localparam logic [6:0] INST_I_IMM = 7'b0010011;
  localparam logic [6:0] INST_S     = 7'b0100011;
  localparam logic [6:0] INST_B     = 7'b1100011;
  localparam logic [6:0] INST_J     = 7'b1101111;
  localparam logic [6:0] INST_U     = 7'b0110111;

  typedef struct packed {
    logic                        v;
    logic [REG_NUM_BITWIDTH-1:0] rd;
    logic                        wr;
    logic                        ld;
  } shadow_entry_t;

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// ID-stage sequencing bus: decoded instruction and pipeline status in,
// PC / IF/ID / ID/EX steering and perf counters out.
interface id_hazard_ctrl_if #(
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int CNT_BITWIDTH     = 16
);
  logic                        id_valid;
  logic [6:0]                  id_opcode;
  logic [REG_NUM_BITWIDTH-1:0] id_rs1;
  logic [REG_NUM_BITWIDTH-1:0] id_rs2;
  logic [REG_NUM_BITWIDTH-1:0] id_rd;
  logic                        id_regWrite;
  logic                        id_memRead;
  logic                        ex_branch_taken;
  logic                        mem_ready;
  logic                        pc_write;
  logic                        ifid_write;
  logic                        ifid_flush;
  logic                        idex_bubble;
  logic                        pipe_freeze;
  logic [CNT_BITWIDTH-1:0]     stall_cnt;
  logic [CNT_BITWIDTH-1:0]     flush_cnt;

  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd, id_regWrite, id_memRead,
    output ex_branch_taken, mem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, id_regWrite, id_memRead,
    input  ex_branch_taken, mem_ready,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_BITWIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc,
  output logic [CNT_BITWIDTH-1:0] cnt
);
  logic [CNT_BITWIDTH-1:0] cnt_q;
  logic [CNT_BITWIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: memory-wait freeze, taken-branch flush and
// load-use stall, decided combinationally from a registered EX/MEM shadow.
module id_hazard_ctrl #(
  parameter int         REG_NUM_BITWIDTH = pipe_pkg::REG_NUM_BITWIDTH,
  parameter int         CNT_BITWIDTH     = 16,
  parameter logic [6:0] INST_R           = pipe_pkg::INST_R,
  parameter logic [6:0] INST_I_LD        = pipe_pkg::INST_I_LD,
  parameter logic [6:0] INST_I_IMM       = pipe_pkg::INST_I_IMM,
  parameter logic [6:0] INST_S           = pipe_pkg::INST_S,
  parameter logic [6:0] INST_B           = pipe_pkg::INST_B,
  parameter logic [6:0] INST_J           = pipe_pkg::INST_J,
  parameter logic [6:0] INST_U           = pipe_pkg::INST_U
) (
  input logic              clk,
  input logic              rst,
  id_hazard_ctrl_if.slave  bus
);
  import pipe_pkg::*;

  // bit0: rs1 read, bit1: rs2 read. J, U and unknown opcodes read nothing.
  function automatic logic [1:0] src_used(input logic [6:0] op);
    if (op == INST_R || op == INST_S || op == INST_B) return 2'b11;
    if (op == INST_I_LD || op == INST_I_IMM)          return 2'b01;
    if (op == INST_J || op == INST_U)                 return 2'b00;
    return 2'b00;
  endfunction

  shadow_entry_t ex_q, ex_d, mem_q, mem_d;
  logic [1:0]    used;
  logic          mem_wait, flush, load_use, rs_hit;
  logic          pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze;
  logic          stall_inc, flush_inc;

  always_comb begin
    used     = src_used(bus.id_opcode);
    rs_hit   = (used[0] && (bus.id_rs1 == ex_q.rd)) ||
               (used[1] && (bus.id_rs2 == ex_q.rd));
    mem_wait = mem_q.v && mem_q.ld && !bus.mem_ready;
    flush    = bus.ex_branch_taken && !mem_wait;
    load_use = bus.id_valid && ex_q.v && ex_q.ld && (ex_q.rd != '0) && rs_hit &&
               !mem_wait && !flush;

    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (mem_wait) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
    end else if (flush) begin
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end

    // Frozen pipeline holds both shadows so a deferred branch is re-seen.
    ex_d  = ex_q;
    mem_d = mem_q;
    if (!mem_wait) begin
      mem_d = ex_q;
      if (idex_bubble || !bus.id_valid) begin
        ex_d = '0;
      end else begin
        ex_d.v  = 1'b1;
        ex_d.rd = bus.id_rd;
        ex_d.wr = bus.id_regWrite;
        ex_d.ld = bus.id_memRead;
      end
    end

    stall_inc = !rst && (mem_wait || load_use);
    flush_inc = !rst && flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
    end
  end

  logic unused_shadow;
  assign unused_shadow = ^{mem_q.rd, mem_q.wr};

  sat_counter #(.CNT_BITWIDTH(CNT_BITWIDTH)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(stall_inc), .cnt(bus.stall_cnt)
  );
  sat_counter #(.CNT_BITWIDTH(CNT_BITWIDTH)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(flush_inc), .cnt(bus.flush_cnt)
  );

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.pipe_freeze = pipe_freeze;
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: expected controls/counters are queued per
// step and compared on the falling edge of the same cycle.
module tb_id_hazard_ctrl;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_J  = 7'b1101111;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze}
  localparam logic [4:0] C_RUN   = 5'b11000;
  localparam logic [4:0] C_STALL = 5'b00010;
  localparam logic [4:0] C_FLUSH = 5'b10110;
  localparam logic [4:0] C_WAIT  = 5'b00001;
  localparam logic [4:0] C_RST   = 5'b00110;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_hazard_ctrl_if #(.REG_NUM_BITWIDTH(5), .CNT_BITWIDTH(16)) bus ();
  id_hazard_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  logic [36:0] exp_q[$];
  string       tag_q[$];
  int          passed = 0;
  int          total  = 0;

  task automatic set_inst(input logic v, input logic [6:0] op, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [4:0] rd,
                          input logic rw, input logic mr);
    bus.id_valid    = v;
    bus.id_opcode   = op;
    bus.id_rs1      = r1;
    bus.id_rs2      = r2;
    bus.id_rd       = rd;
    bus.id_regWrite = rw;
    bus.id_memRead  = mr;
  endtask

  task automatic cyc(input string tag, input logic [4:0] ctl,
                     input logic [15:0] sc, input logic [15:0] fc);
    logic [36:0] obs, e;
    string       t;
    exp_q.push_back({ctl, sc, fc});
    tag_q.push_back(tag);
    @(negedge clk);
    obs = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_bubble,
           bus.pipe_freeze, bus.stall_cnt, bus.flush_cnt};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    total++;
    assert (obs === e) passed++;
    else $error("FAIL %s: observed ctl=%b stall=%h flush=%h, expected ctl=%b stall=%h flush=%h",
                t, obs[36:32], obs[31:16], obs[15:0], e[36:32], e[31:16], e[15:0]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.ex_branch_taken = 1'b0;
    bus.mem_ready       = 1'b1;
    set_inst(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", C_RST, 16'd0, 16'd0);

    // Load-use: lw x5 then add x6,x5,x1
    rst = 1'b0;
    set_inst(1'b1, OP_LD, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
    cyc("first_after_rst", C_RUN, 16'd0, 16'd0);
    set_inst(1'b1, OP_R, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
    cyc("load_use_stall", C_STALL, 16'd0, 16'd0);
    cyc("load_use_resume", C_RUN, 16'd1, 16'd0);

    // x0 destination and no-source opcode never stall
    set_inst(1'b1, OP_LD, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1);
    cyc("lw_x0", C_RUN, 16'd1, 16'd0);
    set_inst(1'b1, OP_R, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
    cyc("use_x0", C_RUN, 16'd1, 16'd0);
    set_inst(1'b1, OP_LD, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
    cyc("lw_x5_b", C_RUN, 16'd1, 16'd0);
    set_inst(1'b1, OP_J, 5'd5, 5'd5, 5'd1, 1'b1, 1'b0);
    cyc("jal_no_use", C_RUN, 16'd1, 16'd0);

    // Taken branch beats a load-use candidate
    set_inst(1'b1, OP_LD, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
    cyc("lw_x5_c", C_RUN, 16'd1, 16'd0);
    set_inst(1'b1, OP_R, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
    bus.ex_branch_taken = 1'b1;
    cyc("flush_over_lu", C_FLUSH, 16'd1, 16'd0);
    bus.ex_branch_taken = 1'b0;
    set_inst(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc("after_flush", C_RUN, 16'd1, 16'd1);

    // Memory wait for 3 cycles
    set_inst(1'b1, OP_LD, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1);
    cyc("lw_x7", C_RUN, 16'd1, 16'd1);
    set_inst(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc("lw_x7_to_mem", C_RUN, 16'd1, 16'd1);
    bus.mem_ready = 1'b0;
    cyc("wait1", C_WAIT, 16'd1, 16'd1);
    cyc("wait2", C_WAIT, 16'd2, 16'd1);
    cyc("wait3", C_WAIT, 16'd3, 16'd1);
    bus.mem_ready = 1'b1;
    cyc("wait_done", C_RUN, 16'd4, 16'd1);

    // Deferred flush during memory wait
    set_inst(1'b1, OP_LD, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1);
    cyc("lw_x7_b", C_RUN, 16'd4, 16'd1);
    set_inst(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc("lw_x7_b_mem", C_RUN, 16'd4, 16'd1);
    bus.mem_ready       = 1'b0;
    bus.ex_branch_taken = 1'b1;
    cyc("defer1", C_WAIT, 16'd4, 16'd1);
    cyc("defer2", C_WAIT, 16'd5, 16'd1);
    bus.mem_ready = 1'b1;
    cyc("deferred_flush", C_FLUSH, 16'd6, 16'd1);
    bus.ex_branch_taken = 1'b0;
    cyc("after_deferred", C_RUN, 16'd6, 16'd2);

    // Reset in the middle of a load-use stall
    set_inst(1'b1, OP_LD, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
    cyc("lw_x5_d", C_RUN, 16'd6, 16'd2);
    set_inst(1'b1, OP_R, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
    rst = 1'b1;
    cyc("rst_mid_lu", C_RST, 16'd6, 16'd2);
    rst = 1'b0;
    cyc("post_rst_clear", C_RUN, 16'd0, 16'd0);

    // Saturation of the stall counter
    set_inst(1'b1, OP_LD, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1);
    cyc("sat_lw", C_RUN, 16'd0, 16'd0);
    set_inst(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc("sat_lw_mem", C_RUN, 16'd0, 16'd0);
    bus.mem_ready = 1'b0;
    repeat (65541) @(posedge clk);
    #1;
    cyc("stall_saturated", C_WAIT, 16'hFFFF, 16'd0);
    cyc("stall_stays_sat", C_WAIT, 16'hFFFF, 16'd0);
    bus.mem_ready = 1'b1;
    cyc("sat_release", C_RUN, 16'hFFFF, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
